ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte per request to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Runs alongside the existing PS/2 receive path on the same two open-drain lines and drives them only through low-active output enables.
- `busy` tells the receive path to ignore line activity while a host frame is in flight.

Parameters:
- INHIBIT_CYCLES, 5000, sys_clk cycles the host holds ps2_clk low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum sys_clk cycles between consecutive device clock falling edges before the frame is aborted (15 ms at 50 MHz).

Ports:
- sys_clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tx_data  input  8  command byte to send
- tx_valid  input  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  output  1  high only in IDLE
- tx_done  output  1  one-cycle pulse: frame sent and acknowledged
- tx_err  output  1  one-cycle pulse: timeout or missing ack
- busy  output  1  high in every state except IDLE
- ps2_clk  input  1  raw PS/2 clock line (asynchronous)
- ps2_data  input  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  output  1  1 = pull clock line low, 0 = release
- ps2_data_oe  output  1  1 = pull data line low, 0 = release

Behaviour:
- Reset (rst=1 at a sys_clk edge):
  - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0.
  - Synchronizer flops reset to 1; bit counter and timers reset to 0.
  - tx_ready=0 while rst is high, 1 on the first cycle after.
  - Reset mid-frame releases both lines on the next edge; no done/err pulse is generated.
- Input sync and edge detect:
  - ps2_clk and ps2_data pass through two flops each; ps2_clk gets a third "previous" flop.
  - fall = prev & ~sync_clk. A pin edge is seen 3 cycles later.
- On accept:
  - Latch tx_data into a shift register.
  - parity = ~^tx_data, giving odd parity over the 8 data bits plus the parity bit.
  - Go to INHIBIT.
- State machine:
  - IDLE: oe both 0; tx_ready=1.
  - INHIBIT: ps2_clk_oe=1. Counter runs 0..INHIBIT_CYCLES-1. On the last count, set ps2_data_oe=1 (start bit 0) and go to REQ. Clock stays low exactly INHIBIT_CYCLES cycles.
  - REQ: ps2_clk_oe=0, ps2_data_oe=1. Wait for fall.
  - Data transmission (the host drives each bit while the clock is low; the device samples it on the rising edge):
    - Falls 1..8: ps2_data_oe = ~bit[i], i=0..7, LSB first. A 1 bit releases the line; a 0 bit pulls it low.
    - Fall 9: ps2_data_oe = ~parity.
    - Fall 10: ps2_data_oe=0 (stop bit, line released); go to ACK.
    - A 4-bit counter tracks falls.
  - ACK: on the next fall, sample synced data. Data 0 → DONE; data 1 → ERR.
  - DONE: tx_done=1 for one cycle; then IDLE.
  - ERR: tx_err=1 for one cycle; oe both 0; then IDLE.
- Timeout:
  - Counter is cleared on entry to REQ and on every fall; it runs in REQ, data and ACK.
  - Reaching TIMEOUT_CYCLES → ERR.
  - In ERR both lines are released in the same cycle tx_err rises.
- Simultaneous events:
  - tx_valid while busy is ignored and the byte is not queued.
  - A fall coinciding with timeout expiry counts as the fall; the timeout is discarded.
  - tx_done and tx_err are never high together.
- tx_ready is back to 1 on the cycle after the done/err pulse, so back-to-back sends are allowed.

Test Plan:
- Send 0xED (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000). Bench device model clocks at a 40-cycle period and pulls data low on the ack edge. Required response:
  - ps2_clk_oe low-drive held exactly 20 cycles.
  - Sampled bits: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, 1 cycle wide; tx_ready=1 on the following cycle.
- Send 0x00 → data bits all 0, parity 1, stop 1; tx_done pulse. Immediately send 0xFF → parity 1; second tx_done pulse.
- Device leaves data high on the ack edge → tx_err 1-cycle pulse, no tx_done, both oe=0, state IDLE.
- Device never clocks after REQ → tx_err exactly TIMEOUT_CYCLES cycles after entering REQ; both oe=0.
- tx_valid held high with 0x55 then 0xAA changed mid-frame → only 0x55 transmitted; 0xAA sent only if still valid once tx_ready=1.
- rst asserted after the 4th falling edge → next cycle oe both 0, busy=0, no done/err pulse; a new send afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. It shares the open-drain clock and data
// lines with the receive path and drives them only through the low-active *_oe outputs.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, DATA, ACK, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          clk_s1_q, clk_s1_d;
  logic          clk_s2_q, clk_s2_d;
  logic          clk_prev_q, clk_prev_d;
  logic          data_s1_q, data_s1_d;
  logic          data_s2_q, data_s2_d;
  logic          fall;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    data_s1_d  = ps2_data;
    data_s2_d  = data_s1_q;
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d   = state_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    timer_d   = timer_q;
    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          sh_d      = {~^tx_data, tx_data};
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      REQ, DATA, ACK: begin
        // A fall in the same cycle as timeout expiry wins over the timeout.
        if (fall) begin
          timer_d = '0;
          if (state_q == ACK) begin
            state_d = data_s2_q ? ERR : DONE;
          end else if (state_q == DATA && bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~sh_q[0];
            sh_d      = {1'b1, sh_q[8:1]};
            bit_cnt_d = (state_q == REQ) ? 4'd1 : bit_cnt_q + 1'b1;
            state_d   = DATA;
          end
        end else if (timer_q == TMO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      timer_q    <= '0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      timer_q    <= timer_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
    end
  end

  assign tx_ready    = (state_q == IDLE) & ~rst;
  assign busy        = (state_q != IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == ERR);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines and a per-cycle rule checker.
module tb_ps2_host_tx;

  logic       sys_clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int last_inh = 0;
  int inh_run  = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk    (ps2_clk_line),
    .ps2_data   (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Expected 11-bit frame, bit 0 = start bit: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return busy;
      1: return tx_done;
      2: return tx_ready;
      3: return ps2_clk_oe;
      4: return !ps2_clk_oe;
      5: return tx_err;
      default: return tx_done | tx_err;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int lim, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge sys_clk);
      hit = sig(sel);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles, required it", name, lim);
    end
  endtask

  // Per-cycle rule checks that hold whatever the stimulus.
  initial begin
    bit prev_done = 1'b0, prev_err = 1'b0;
    forever begin
      @(negedge sys_clk);
      #1;
      check("done_err_exclusive", {31'd0, tx_done & tx_err}, 32'd0);
      if (!rst) check("ready_is_not_busy", {31'd0, tx_ready}, {31'd0, !busy});
      if (!busy) check("idle_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      if (tx_done && prev_done) check("done_width", 32'd2, 32'd1);
      if (tx_err && prev_err) check("err_width", 32'd2, 32'd1);
      if (tx_done && !prev_done) done_cnt++;
      if (tx_err && !prev_err) err_cnt++;
      prev_done = tx_done;
      prev_err  = tx_err;
      if (ps2_clk_oe) inh_run++;
      else if (inh_run > 0) begin
        last_inh = inh_run;
        inh_run  = 0;
      end
    end
  end

  // Device: clocks at a 40-cycle period and samples data just before each rising edge.
  task automatic dev_frame(input bit ack_low, input int max_falls, output logic [10:0] bits);
    bits = '1;
    wait_for(3, 100, "dev_inhibit");
    wait_for(4, 100, "dev_req");
    repeat (5) @(negedge sys_clk);
    bits[0] = ps2_data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge sys_clk);
      if (i == max_falls) return;
      repeat (10) @(negedge sys_clk);
      bits[i] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge sys_clk);
    end
    if (ack_low) dev_data_low = 1'b1;
    repeat (5) @(negedge sys_clk);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge sys_clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  // Host side of one request; with chain set tx_valid stays high and tx_data changes mid-frame.
  task automatic host_side(input bit chain, input logic [7:0] nxt, input int dly, input bit exp_err);
    wait_for(0, 50, "accept");
    if (!chain) tx_valid = 1'b0;
    else begin
      repeat (dly) @(negedge sys_clk);
      tx_data = nxt;
    end
    wait_for(6, 1500, "frame_end");
    check("end_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("pulse_kind", {30'd0, tx_done, tx_err}, exp_err ? 32'd1 : 32'd2);
    @(negedge sys_clk);
    check("ready_after_pulse", {31'd0, tx_ready}, 32'd1);
    if (chain) begin
      wait_for(0, 50, "accept_next");
      tx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [10:0] b1, b2;
    int d0, e0, c0;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_outputs", {26'd0, tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    rst = 1'b0;
    @(negedge sys_clk);
    check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

    // 0xED with ack
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hED; tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 11, b1);
      host_side(1'b0, 8'h00, 0, 1'b0);
    join
    check("frame_ED", {21'd0, b1}, 32'h7DA);
    check("inhibit_len_ED", last_inh, 20);
    check("done_once_ED", done_cnt - d0, 1);
    check("no_err_ED", err_cnt - e0, 0);

    // 0x00 then immediately 0xFF
    d0 = done_cnt;
    tx_data = 8'h00; tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 11, b1);
      host_side(1'b1, 8'hFF, 5, 1'b0);
    join
    check("frame_00", {21'd0, b1}, 32'h600);
    dev_frame(1'b1, 11, b2);
    check("frame_FF", {21'd0, b2}, 32'h7FE);
    check("inhibit_len_FF", last_inh, 20);
    check("done_twice", done_cnt - d0, 2);

    // Missing ack
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hF4; tx_valid = 1'b1;
    fork
      dev_frame(1'b0, 11, b1);
      host_side(1'b0, 8'h00, 0, 1'b1);
    join
    check("frame_F4_nack", {21'd0, b1}, {21'd0, frame_of(8'hF4)});
    check("nack_err_once", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);

    // Device never clocks
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hF4; tx_valid = 1'b1;
    wait_for(0, 50, "to_accept");
    tx_valid = 1'b0;
    wait_for(3, 50, "to_inhibit");
    wait_for(4, 50, "to_req");
    c0 = cyc;
    wait_for(5, 2100, "to_err");
    check("timeout_len", cyc - c0, 2000);
    check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge sys_clk);
    check("timeout_idle", {30'd0, tx_ready, busy}, 32'd2);
    check("timeout_counts", (err_cnt - e0) * 16 + (done_cnt - d0), 16);
    check("inhibit_len_to", last_inh, 20);

    // tx_valid held, data changed mid-frame
    tx_data = 8'h55; tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 11, b1);
      host_side(1'b1, 8'hAA, 100, 1'b0);
    join
    check("frame_55", {21'd0, b1}, 32'h6AA);
    dev_frame(1'b1, 11, b2);
    check("frame_AA", {21'd0, b2}, {21'd0, frame_of(8'hAA)});

    // Reset after the 4th falling edge
    tx_data = 8'hED; tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 4, b1);
      begin
        wait_for(0, 50, "rst_accept");
        tx_valid = 1'b0;
      end
    join
    check("partial_ED", {28'd0, b1[3:0]}, 32'hA);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_outputs", {26'd0, tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    rst = 1'b0; dev_clk_low = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("midrst_no_pulse", (err_cnt - e0) * 16 + (done_cnt - d0), 0);
    check("midrst_idle", {30'd0, tx_ready, busy}, 32'd2);
    tx_data = 8'h0F; tx_valid = 1'b1;
    fork
      dev_frame(1'b1, 11, b1);
      host_side(1'b0, 8'h00, 0, 1'b0);
    join
    check("frame_after_rst", {21'd0, b1}, {21'd0, frame_of(8'h0F)});
    check("done_after_rst", done_cnt - d0, 1);

    repeat (5) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
